// File: rtl/m706_pkg.sv
// Shared definitions for the m706 console teletype receiver.
//   rx_state_t      receiver FSM states
//   IOP_*           IOP pulse bit positions used by the IOT decode
//   DEF_*           default frame geometry
package m706_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int IOP_SKIP = 1;  // KSF
  localparam int IOP_CLR  = 2;  // KCC
  localparam int IOP_READ = 4;  // KRS

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 8;

endpackage

// File: rtl/tty_bit_timer.sv
// Oversampling bit timer for the teletype serial paths.
// A log2(OVERSAMPLE)-bit counter advanced only on baud ticks, with two strobes:
//   mid_stb  fires on the tick that brings the count to OVERSAMPLE/2-1 (start-bit centre)
//   end_stb  fires on the tick taken at count OVERSAMPLE-1 (one full bit time)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick         1-clk baud enable
//   clr          on a tick, load the counter with 0 instead of advancing
//   mid_stb      mid-start-bit strobe (tick qualified)
//   end_stb      end-of-bit strobe (tick qualified)
module tty_bit_timer #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  output logic mid_stb,
  output logic end_stb
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_PRE_MID = CW'(OVERSAMPLE / 2 - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = clr ? '0 : cnt_q + CW'(1);  // natural wrap at OVERSAMPLE
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_stb = tick & (cnt_q == CNT_PRE_MID);
  assign end_stb = tick & (cnt_q == CNT_LAST);

endmodule

// File: rtl/m706_tty_rx.sv
// Console teletype receiver (keyboard/reader, device 03).
// Deserialises the async current-loop line into a buffer, raises the keyboard
// flag, decodes KSF/KCC/KRS/KRB and drives the reader-run relay.
// Optional feature macro: M706_FRAMING_ERR_EN (stop-bit framing error flag).
// Ports:
//   clk          system clock
//   io_clr_n     asynchronous active-low IO/power clear
//   baud_tick    1-clk enable at OVERSAMPLE x bit rate
//   serial_in    line state, 1 = mark/idle (asynchronous)
//   dev_sel      device 03 selected, IOT in progress
//   iop1/2/4     IOP pulses
//   skip         PC skip request (KSF)
//   ac_clr       AC clear request (KCC)
//   data_oe      data_out onto AC bus (KRS)
//   data_out     receive buffer
//   flag         keyboard flag
//   reader_run   reader relay enable
//   framing_err  stop bit received as space (0 unless M706_FRAMING_ERR_EN)
module m706_tty_rx
  import m706_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 io_clr_n,
  input  logic                 baud_tick,
  input  logic                 serial_in,
  input  logic                 dev_sel,
  input  logic                 iop1,
  input  logic                 iop2,
  input  logic                 iop4,
  output logic                 skip,
  output logic                 ac_clr,
  output logic                 data_oe,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 flag,
  output logic                 reader_run,
  output logic                 framing_err
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BITN_LAST = BW'(DATA_BITS - 1);

  // 2-FF synchroniser, reset to mark so a cleared line looks idle
  logic sync1_q, sync2_q;
  logic rxd;

  always_ff @(posedge clk or negedge io_clr_n) begin
    if (!io_clr_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  assign rxd = sync2_q;

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 flag_q, flag_d;
  logic                 rrun_q, rrun_d;

  logic kcc;
  logic start_det;
  logic char_done;
  logic timer_clr;
  logic mid_stb, end_stb;

  assign kcc       = dev_sel & iop2;
  assign start_det = baud_tick & (state_q == IDLE) & ~rxd;
  assign char_done = (state_q == STOP) & end_stb;
  // Counter is held at 0 while idle and restarted at the start-bit centre so
  // every later end strobe lands in the middle of a bit cell.
  assign timer_clr = (state_q == IDLE) | ((state_q == START) & mid_stb);

  tty_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (io_clr_n),
    .tick   (baud_tick),
    .clr    (timer_clr),
    .mid_stb(mid_stb),
    .end_stb(end_stb)
  );

  always_comb begin
    state_d = state_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (mid_stb) begin
          state_d = rxd ? IDLE : DATA;  // high at centre: glitch, re-arm
          bitn_d  = '0;
        end
      end
      DATA: begin
        if (end_stb) begin
          shreg_d = {rxd, shreg_q[DATA_BITS-1:1]};  // LSB first
          bitn_d  = bitn_q + BW'(1);
          if (bitn_q == BITN_LAST) state_d = STOP;
        end
      end
      STOP: begin
        // Load at the stop-bit centre; no wait for the end of the stop bit.
        if (end_stb) begin
          buf_d   = shreg_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion beats a coincident KCC so the new character is never lost.
  assign flag_d = char_done ? 1'b1 : (kcc ? 1'b0 : flag_q);
  // A fresh start bit drops the reader relay even if KCC asks for a step.
  assign rrun_d = start_det ? 1'b0 : (kcc ? 1'b1 : rrun_q);

  always_ff @(posedge clk or negedge io_clr_n) begin
    if (!io_clr_n) begin
      state_q <= IDLE;
      bitn_q  <= '0;
      shreg_q <= '0;
      buf_q   <= '0;
      flag_q  <= 1'b0;
      rrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      flag_q  <= flag_d;
      rrun_q  <= rrun_d;
    end
  end

`ifdef M706_FRAMING_ERR_EN
  logic ferr_q, ferr_d;

  assign ferr_d = (char_done & ~rxd) ? 1'b1 : (kcc ? 1'b0 : ferr_q);

  always_ff @(posedge clk or negedge io_clr_n) begin
    if (!io_clr_n) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign framing_err = ferr_q;
`else
  assign framing_err = 1'b0;
`endif

  assign skip       = dev_sel & iop1 & flag_q;
  assign ac_clr     = kcc;
  assign data_oe    = dev_sel & iop4;
  assign data_out   = buf_q;
  assign flag       = flag_q;
  assign reader_run = rrun_q;

endmodule

// File: tb/tb_m706_tty_rx.sv
// Bench for m706_tty_rx: directed frames and IOTs; KRS reads are checked by a
// scoreboard monitor, flag/IOT/timing behaviour by inline checks.
module tb_m706_tty_rx;

  logic       clk = 1'b0;
  logic       io_clr_n;
  logic       baud_tick;
  logic       serial_in;
  logic       dev_sel;
  logic       iop1;
  logic       iop2;
  logic       iop4;
  logic       skip;
  logic       ac_clr;
  logic       data_oe;
  logic [7:0] data_out;
  logic       flag;
  logic       reader_run;
  logic       framing_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

`ifdef M706_FRAMING_ERR_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  m706_tty_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(8)
  ) dut (
    .clk        (clk),
    .io_clr_n   (io_clr_n),
    .baud_tick  (baud_tick),
    .serial_in  (serial_in),
    .dev_sel    (dev_sel),
    .iop1       (iop1),
    .iop2       (iop2),
    .iop4       (iop4),
    .skip       (skip),
    .ac_clr     (ac_clr),
    .data_oe    (data_oe),
    .data_out   (data_out),
    .flag       (flag),
    .reader_run (reader_run),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  // baud tick: one clock in every four
  initial begin
    int tdiv;
    tdiv = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      baud_tick = (tdiv == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // returns just after the posedge on which baud_tick was high
  task automatic wait_tick();
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      if (baud_tick) break;
      k++;
      if (k > 16) begin
        checks++;
        errors++;
        $display("FAIL tick_wait: no baud tick within 16 clocks");
        break;
      end
    end
  endtask

  // Send one frame. Tick n counts from the tick that sees the start bit (n=0).
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input bit chk_time,
                            input bit kcc_on_set, input int abort_at);
    logic [9:0] lv;
    int n;
    lv = {stop_lvl, d, 1'b0};
    wait_tick();
    @(negedge clk);
    serial_in = 1'b0;
    n = 0;
    while (n < 80) begin
      wait_tick();
      #1;
      if (chk_time && n == 74) chk("flag_before_t75", flag, 0);
      if (chk_time && n == 75) chk("flag_at_t75", flag, 1);
      if (abort_at == n) begin
        @(negedge clk);
        serial_in = 1'b1;
        return;
      end
      @(negedge clk);
      serial_in = (n >= 75) ? 1'b1 : lv[(n+1)/8];
      if (kcc_on_set && n == 74) begin
        // KCC pulse aligned exactly with the tick-75 edge
        repeat (3) @(negedge clk);
        dev_sel = 1'b1;
        iop2    = 1'b1;
        @(posedge clk);
        #1;
        chk("flag_set_wins", flag, 1);
        chk("rrun_kcc_on_set", reader_run, 1);
        @(negedge clk);
        dev_sel = 1'b0;
        iop2    = 1'b0;
        n++;
      end
      n++;
    end
  endtask

  task automatic iot(input string nm, input logic p1, input logic p2, input logic p4,
                     input logic e_skip, input logic e_acclr, input logic e_oe,
                     input logic [7:0] e_data);
    @(negedge clk);
    dev_sel = 1'b1;
    iop1 = p1;
    iop2 = p2;
    iop4 = p4;
    if (p4) exp_q.push_back(e_data);
    #1;
    chk({nm, "_skip"}, skip, e_skip);
    chk({nm, "_ac_clr"}, ac_clr, e_acclr);
    chk({nm, "_data_oe"}, data_oe, e_oe);
    @(negedge clk);
    dev_sel = 1'b0;
    iop1 = 1'b0;
    iop2 = 1'b0;
    iop4 = 1'b0;
  endtask

  // scoreboard monitor: every bus read is compared with the next expected char
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (data_oe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL krs_unexpected: data_oe with data %0h, nothing expected", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("krs_data", data_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    io_clr_n  = 1'b0;
    serial_in = 1'b1;
    dev_sel   = 1'b0;
    iop1      = 1'b0;
    iop2      = 1'b0;
    iop4      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flag", flag, 0);
    chk("rst_reader_run", reader_run, 0);
    chk("rst_framing_err", framing_err, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_skip", skip, 0);
    chk("rst_ac_clr", ac_clr, 0);
    chk("rst_data_oe", data_oe, 0);
    io_clr_n = 1'b1;
    repeat (10) wait_tick();

    // 1: frame 0x8D, flag at tick 75, KRS does not clear flag
    send_frame(8'h8D, 1'b1, 1'b1, 1'b0, -1);
    chk("f1_framing_err", framing_err, 0);
    iot("krs1", 0, 0, 1, 0, 0, 1, 8'h8D);
    chk("krs1_flag_kept", flag, 1);

    // 2: KSF unselected / selected, KCC, KSF again
    @(negedge clk);
    iop1 = 1'b1;
    #1;
    chk("ksf_unselected_skip", skip, 0);
    @(negedge clk);
    iop1 = 1'b0;
    iot("ksf1", 1, 0, 0, 1, 0, 0, 8'h00);
    iot("kcc1", 0, 1, 0, 0, 1, 0, 8'h00);
    chk("kcc1_flag", flag, 0);
    chk("kcc1_reader_run", reader_run, 1);
    iot("ksf2", 1, 0, 0, 0, 0, 0, 8'h00);

    // 3: 3-tick space glitch on idle line
    wait_tick();
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) wait_tick();
    @(negedge clk);
    serial_in = 1'b1;
    wait_tick();
    #1;
    chk("glitch_reader_run_dropped", reader_run, 0);
    repeat (90) wait_tick();
    #1;
    chk("glitch_no_flag", flag, 0);
    iot("krs_glitch", 0, 0, 1, 0, 0, 1, 8'h8D);

    // 4: 0x33 sets flag, then 0x41 overruns it with KCC on the set edge
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, -1);
    iot("krs33", 0, 0, 1, 0, 0, 1, 8'h33);
    send_frame(8'h41, 1'b1, 1'b0, 1'b1, -1);
    chk("overrun_flag", flag, 1);
    iot("krs41", 0, 0, 1, 0, 0, 1, 8'h41);

    // 5: reset in bit 4 of a frame, then 0xFF
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 40);
    @(negedge clk);
    io_clr_n = 1'b0;
    #1;
    chk("midreset_flag", flag, 0);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_reader_run", reader_run, 0);
    @(negedge clk);
    io_clr_n = 1'b1;
    repeat (20) wait_tick();
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, -1);
    iot("krsFF", 0, 0, 1, 0, 0, 1, 8'hFF);
    iot("krbFF", 0, 1, 1, 0, 1, 1, 8'hFF);
    chk("krb_flag", flag, 0);

    // 6: stop bit sent as space
    repeat (5) wait_tick();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    chk("ferr_set", framing_err, FE_EXP);
    iot("krs5A", 0, 0, 1, 0, 0, 1, 8'h5A);
    iot("kcc_ferr", 0, 1, 0, 0, 1, 0, 8'h00);
    chk("kcc_ferr_flag", flag, 0);
    chk("kcc_ferr_cleared", framing_err, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
